// File: rtl/kf8237_dreq_generator_pkg.sv
// Shared types for the KF8237 DREQ generator: the job state machine encoding.
package KF8237_Common_Package;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_READY = 3'd1,
    REQUEST    = 3'd2,
    ACKED      = 3'd3,
    TERMINATE  = 3'd4
  } dreq_state_t;

endpackage

// File: rtl/kf8237_dreq_generator_counter.sv
// Transfer counter: loads (transfers - 1) at job start and steps down once per
// moved word; terminal flags the final transfer and the count never wraps.
module KF8237_Transfer_Counter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_value,
  input  logic                   decrement,
  output logic [COUNT_WIDTH-1:0] remaining,
  output logic                   terminal
);

  // A decrement at zero is the terminal transfer, so the count holds at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= load_value;
    end else if (decrement && (remaining != '0)) begin
      remaining <= remaining - 1'b1;
    end
  end

  assign terminal = (remaining == '0);

endmodule

// File: rtl/kf8237_dreq_generator.sv
// Peripheral-side DREQ generator for an 8237-style DMA controller.
// Define KF8237_DREQ_TC_COUNTER_EN to add the transfer counter and peripheral TC.
module kf8237_dreq_generator
  import KF8237_Common_Package::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   demand_mode,
  input  logic [COUNT_WIDTH-1:0] transfer_count,
  input  logic                   data_ready,
  input  logic                   dma_acknowledge,
  input  logic                   io_strobe,
  input  logic                   end_of_process_in,
  output logic                   dma_request,
  output logic                   end_of_process_out,
  output logic                   transfer_strobe,
  output logic                   done,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] remaining
);

  dreq_state_t            state;
  logic                   demand_latched;
  logic                   strobe_prev;
  logic                   moved_this_dack;
  logic                   strobe_edge;
  logic                   transfer_accept;
  logic                   load_counter;
  logic                   terminal_count;
  logic                   tc_event;
  logic [COUNT_WIDTH-1:0] count_value;

  // Single mode moves one word per DACK; demand mode takes every strobe edge.
  assign strobe_edge     = io_strobe && !strobe_prev;
  assign transfer_accept = (state == ACKED) && dma_acknowledge && strobe_edge && !stop &&
                           (demand_latched || !moved_this_dack);
  assign load_counter    = (state == IDLE) && start && !stop;
  assign tc_event        = transfer_accept && terminal_count;
  assign busy            = (state != IDLE);

`ifdef KF8237_DREQ_TC_COUNTER_EN
  KF8237_Transfer_Counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_transfer_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (load_counter),
    .load_value (transfer_count),
    .decrement  (transfer_accept),
    .remaining  (count_value),
    .terminal   (terminal_count)
  );
`else
  logic unused_config;
  assign count_value    = '0;
  assign terminal_count = 1'b0;
  assign unused_config  = ^{transfer_count, load_counter};
`endif

  assign remaining = count_value;

  // Job sequencer; stop overrides every other event once a job is running.
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      dma_request        <= 1'b0;
      end_of_process_out <= 1'b0;
      transfer_strobe    <= 1'b0;
      done               <= 1'b0;
      demand_latched     <= 1'b0;
      strobe_prev        <= 1'b0;
      moved_this_dack    <= 1'b0;
    end else begin
      strobe_prev        <= io_strobe;
      end_of_process_out <= 1'b0;
      transfer_strobe    <= transfer_accept;
      done               <= 1'b0;
      if (transfer_accept) begin
        moved_this_dack <= 1'b1;
      end

      if ((state != IDLE) && stop) begin
        dma_request <= 1'b0;
        if (dma_acknowledge) begin
          state <= TERMINATE;
        end else begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              state          <= WAIT_READY;
              demand_latched <= demand_mode;
            end
          end

          WAIT_READY: begin
            if (data_ready) begin
              state       <= REQUEST;
              dma_request <= 1'b1;
            end
          end

          REQUEST: begin
            if (dma_acknowledge) begin
              state           <= ACKED;
              dma_request     <= demand_latched;
              moved_this_dack <= 1'b0;
            end
          end

          // A terminal event needs DACK still asserted; DACK dropping re-arms the request.
          ACKED: begin
            if (dma_acknowledge && (tc_event || end_of_process_in)) begin
              state              <= TERMINATE;
              dma_request        <= 1'b0;
              end_of_process_out <= tc_event;
            end else if (!dma_acknowledge) begin
              state       <= WAIT_READY;
              dma_request <= 1'b0;
            end else if (demand_latched && !data_ready) begin
              dma_request <= 1'b0;
            end
          end

          TERMINATE: begin
            dma_request <= 1'b0;
            if (!dma_acknowledge) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end

          default: begin
            state       <= IDLE;
            dma_request <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kf8237_dreq_generator.sv
// Scoreboard bench for kf8237_dreq_generator; expectations adapt to whether
// KF8237_DREQ_TC_COUNTER_EN is defined.
module tb_kf8237_dreq_generator;

  localparam int COUNT_WIDTH = 16;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   start = 1'b0;
  logic                   stop = 1'b0;
  logic                   demand_mode = 1'b0;
  logic [COUNT_WIDTH-1:0] transfer_count = '0;
  logic                   data_ready = 1'b0;
  logic                   dma_acknowledge = 1'b0;
  logic                   io_strobe = 1'b0;
  logic                   end_of_process_in = 1'b0;
  logic                   dma_request;
  logic                   end_of_process_out;
  logic                   transfer_strobe;
  logic                   done;
  logic                   busy;
  logic [COUNT_WIDTH-1:0] remaining;

  typedef struct {
    logic        is_done;
    logic [15:0] rem;
    logic        eop;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_item;
  int   test_count = 0;
  int   fail_count = 0;

  kf8237_dreq_generator #(.COUNT_WIDTH(COUNT_WIDTH)) dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .stop               (stop),
    .demand_mode        (demand_mode),
    .transfer_count     (transfer_count),
    .data_ready         (data_ready),
    .dma_acknowledge    (dma_acknowledge),
    .io_strobe          (io_strobe),
    .end_of_process_in  (end_of_process_in),
    .dma_request        (dma_request),
    .end_of_process_out (end_of_process_out),
    .transfer_strobe    (transfer_strobe),
    .done               (done),
    .busy               (busy),
    .remaining          (remaining)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] exp_rem(input int value);
`ifdef KF8237_DREQ_TC_COUNTER_EN
    return value[15:0];
`else
    return 16'd0 & value[15:0];
`endif
  endfunction

  function automatic logic exp_eop(input logic value);
`ifdef KF8237_DREQ_TC_COUNTER_EN
    return value;
`else
    return 1'b0 & value;
`endif
  endfunction

  task automatic push_strobe(input int rem, input logic eop);
    exp_t e;
    e.is_done = 1'b0;
    e.rem     = exp_rem(rem);
    e.eop     = exp_eop(eop);
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int rem);
    exp_t e;
    e.is_done = 1'b1;
    e.rem     = exp_rem(rem);
    e.eop     = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Launch a job: start is held for exactly one sampling edge.
  task automatic applyStimulus(input logic demand, input int count);
    demand_mode    = demand;
    transfer_count = count[COUNT_WIDTH-1:0];
    start          = 1'b1;
    tick();
    start          = 1'b0;
  endtask

  task automatic pulse_strobe();
    io_strobe = 1'b1;
    tick();
    io_strobe = 1'b0;
    tick();
  endtask

  // Monitor: every word-moved or job-finished pulse consumes one expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (transfer_strobe || done) begin
        if (exp_q.size() == 0) begin
          test_count++;
          fail_count++;
          $display("[TB] FAIL unexpected_event: got strobe=%0b done=%0b, expected no event",
                   transfer_strobe, done);
        end else begin
          mon_item = exp_q.pop_front();
          checkOutput("event_is_done", {31'd0, done}, {31'd0, mon_item.is_done});
          checkOutput("event_remaining", {16'd0, remaining}, {16'd0, mon_item.rem});
          checkOutput("event_eop_out", {31'd0, end_of_process_out}, {31'd0, mon_item.eop});
        end
      end else if (end_of_process_out) begin
        test_count++;
        fail_count++;
        $display("[TB] FAIL stray_eop_out: got 1, expected 0");
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    tick(2);
    reset = 1'b0;
    tick();
    checkOutput("reset_dreq", {31'd0, dma_request}, 0);
    checkOutput("reset_busy", {31'd0, busy}, 0);
    checkOutput("reset_remaining", {16'd0, remaining}, 0);
    checkOutput("reset_eop_out", {31'd0, end_of_process_out}, 0);
    checkOutput("reset_strobe", {31'd0, transfer_strobe}, 0);
    checkOutput("reset_done", {31'd0, done}, 0);

    // Single mode, request latency, one word per DACK, end by EOP input
    data_ready = 1'b1;
    applyStimulus(1'b0, 7);
    checkOutput("latency_dreq_edge1", {31'd0, dma_request}, 0);
    checkOutput("latency_busy", {31'd0, busy}, 1);
    tick();
    checkOutput("latency_dreq_edge2", {31'd0, dma_request}, 1);
    dma_acknowledge = 1'b1;
    tick();
    checkOutput("single_dreq_cleared_acked", {31'd0, dma_request}, 0);
    checkOutput("single_remaining_loaded", {16'd0, remaining}, {16'd0, exp_rem(7)});
    push_strobe(6, 1'b0);
    pulse_strobe();
    pulse_strobe();
    dma_acknowledge = 1'b0;
    tick(2);
    checkOutput("single_dreq_rearmed", {31'd0, dma_request}, 1);
    dma_acknowledge   = 1'b1;
    tick();
    end_of_process_in = 1'b1;
    tick();
    end_of_process_in = 1'b0;
    checkOutput("eop_in_no_eop_out", {31'd0, end_of_process_out}, 0);
    checkOutput("eop_in_dreq", {31'd0, dma_request}, 0);
    checkOutput("eop_in_busy_terminate", {31'd0, busy}, 1);
    tick(2);
    push_done(6);
    dma_acknowledge = 1'b0;
    tick();
    checkOutput("eop_in_idle", {31'd0, busy}, 0);

    // Demand mode, data_ready drop, re-arm, then stop with DACK high
    applyStimulus(1'b1, 9);
    tick();
    dma_acknowledge = 1'b1;
    tick();
    checkOutput("demand_dreq_held", {31'd0, dma_request}, 1);
    push_strobe(8, 1'b0);
    pulse_strobe();
    push_strobe(7, 1'b0);
    pulse_strobe();
    data_ready = 1'b0;
    tick();
    checkOutput("demand_dreq_drop", {31'd0, dma_request}, 0);
    dma_acknowledge = 1'b0;
    tick(2);
    checkOutput("demand_dreq_waits_ready", {31'd0, dma_request}, 0);
    data_ready = 1'b1;
    tick();
    checkOutput("demand_dreq_rearmed", {31'd0, dma_request}, 1);
    dma_acknowledge = 1'b1;
    tick();
    push_strobe(6, 1'b0);
    pulse_strobe();
    stop      = 1'b1;
    io_strobe = 1'b1;
    tick();
    stop      = 1'b0;
    io_strobe = 1'b0;
    checkOutput("stop_dack_dreq", {31'd0, dma_request}, 0);
    checkOutput("stop_dack_terminate", {31'd0, busy}, 1);
    tick();
    push_done(6);
    dma_acknowledge = 1'b0;
    tick();
    checkOutput("stop_dack_idle", {31'd0, busy}, 0);

    // Stop in REQUEST with DACK low, then start and stop together in IDLE
    applyStimulus(1'b0, 3);
    tick();
    checkOutput("stop_req_dreq_before", {31'd0, dma_request}, 1);
    push_done(3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("stop_req_dreq_after", {31'd0, dma_request}, 0);
    checkOutput("stop_req_idle", {31'd0, busy}, 0);
    stop = 1'b1;
    applyStimulus(1'b1, 5);
    stop = 1'b0;
    checkOutput("start_stop_idle", {31'd0, busy}, 0);
    tick();
    checkOutput("start_stop_no_dreq", {31'd0, dma_request}, 0);

`ifdef KF8237_DREQ_TC_COUNTER_EN
    // Single mode, three transfers ending on terminal count
    applyStimulus(1'b0, 2);
    tick();
    for (int i = 0; i < 3; i++) begin
      dma_acknowledge = 1'b1;
      tick();
      push_strobe((i == 0) ? 1 : 0, i == 2);
      pulse_strobe();
      if (i == 2) push_done(0);
      dma_acknowledge = 1'b0;
      tick();
      if (i < 2) begin
        tick();
        checkOutput("tc_single_dreq", {31'd0, dma_request}, 1);
      end
    end
    checkOutput("tc_single_idle", {31'd0, busy}, 0);

    // Demand mode, five transfers under one DACK
    applyStimulus(1'b1, 4);
    tick();
    dma_acknowledge = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      push_strobe((i < 4) ? (3 - i) : 0, i == 4);
      io_strobe = 1'b1;
      tick();
      io_strobe = 1'b0;
      if (i < 4) checkOutput("tc_demand_dreq", {31'd0, dma_request}, 1);
      tick();
    end
    checkOutput("tc_demand_dreq_end", {31'd0, dma_request}, 0);
    push_done(0);
    dma_acknowledge = 1'b0;
    tick();

    // Count of zero: one transfer, with terminal count and EOP input together
    applyStimulus(1'b0, 0);
    tick();
    dma_acknowledge = 1'b1;
    tick();
    push_strobe(0, 1'b1);
    io_strobe         = 1'b1;
    end_of_process_in = 1'b1;
    tick();
    io_strobe         = 1'b0;
    end_of_process_in = 1'b0;
    tick();
    push_done(0);
    dma_acknowledge = 1'b0;
    tick();
`endif

    // Reset in the middle of a demand job
    applyStimulus(1'b1, 5);
    tick();
    dma_acknowledge = 1'b1;
    tick();
    checkOutput("pre_reset_dreq", {31'd0, dma_request}, 1);
    checkOutput("pre_reset_remaining", {16'd0, remaining}, {16'd0, exp_rem(5)});
    reset = 1'b1;
    tick();
    checkOutput("reset_acked_dreq", {31'd0, dma_request}, 0);
    checkOutput("reset_acked_busy", {31'd0, busy}, 0);
    checkOutput("reset_acked_remaining", {16'd0, remaining}, 0);
    checkOutput("reset_acked_done", {31'd0, done}, 0);
    reset           = 1'b0;
    dma_acknowledge = 1'b0;
    data_ready      = 1'b0;
    tick(3);

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
